// File: rtl/modrm_sequencer_pkg.sv
// Shared definitions for the ModR/M fetch sequencer: FSM encoding,
// opcode classes and ModR/M field constants.
package modrm_sequencer_pkg;

  // Fetch/execute states of the sequencer.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MODRM   = 3'd1,
    DISP_LO = 3'd2,
    DISP_HI = 3'd3,
    EXEC    = 3'd4
  } seq_state_e;

  // Opcode classes that take a ModR/M byte.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ALU  = 3'd1,
    OP_MOV  = 3'd2,
    OP_XCHG = 3'd3,
    OP_MOVI = 3'd4
  } op_kind_e;

  // Opcode match patterns as (mask, value) pairs.
  localparam logic [7:0] ALU_MASK   = 8'hC4;  // 00xxx0xx
  localparam logic [7:0] ALU_MATCH  = 8'h00;
  localparam logic [7:0] MOV_MASK   = 8'hFC;  // 100010xx
  localparam logic [7:0] MOV_MATCH  = 8'h88;
  localparam logic [7:0] XCHG_MASK  = 8'hFE;  // 1000011x
  localparam logic [7:0] XCHG_MATCH = 8'h86;
  localparam logic [7:0] MOVI_MASK  = 8'hFE;  // 1100011x
  localparam logic [7:0] MOVI_MATCH = 8'hC6;

  // ModR/M field values with special meaning.
  localparam logic [1:0] MOD_REG   = 2'b11;   // register operand, no displacement
  localparam logic [2:0] DIRECT_RM = 3'b110;  // with MOD=00: 16-bit direct address

  // Classify an opcode byte; OP_NONE means it takes no ModR/M byte.
  function automatic op_kind_e decode_opcode(input logic [7:0] op);
    op_kind_e kind;
    kind = OP_NONE;
    if ((op & ALU_MASK) == ALU_MATCH)       kind = OP_ALU;
    else if ((op & MOV_MASK) == MOV_MATCH)  kind = OP_MOV;
    else if ((op & XCHG_MASK) == XCHG_MATCH) kind = OP_XCHG;
    else if ((op & MOVI_MASK) == MOVI_MATCH) kind = OP_MOVI;
    return kind;
  endfunction

endpackage

// File: rtl/modrm_sequencer_beat_gen.sv
// Stallable one-hot beat shifter. start_i loads T[0]; each unstalled
// cycle moves the beat up one position; leaving the last beat clears
// T and raises done_o for one cycle.
module modrm_beat_gen #(
  parameter int BEATS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  output logic [BEATS-1:0] t_o,
  output logic             done_o,
  output logic             last_o
);

  logic [BEATS-1:0] t_q, t_d;
  logic             done_q, done_d;

  // Last beat retires this cycle; the fetch FSM returns to IDLE on it.
  assign last_o = t_q[BEATS-1] & ~stall_i;

  // Next beat: load, hold on stall, shift, or retire.
  always_comb begin
    t_d    = t_q;
    done_d = 1'b0;
    if (start_i) begin
      t_d    = '0;
      t_d[0] = 1'b1;
    end else if ((t_q != '0) && !stall_i) begin
      if (t_q[BEATS-1]) begin
        t_d    = '0;
        done_d = 1'b1;
      end else begin
        t_d = t_q << 1;
      end
    end
  end

  // Beat and done registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_q    <= '0;
      done_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      done_q <= done_d;
    end
  end

  assign t_o    = t_q;
  assign done_o = done_q;

endmodule

// File: rtl/modrm_sequencer.sv
// ModR/M fetch sequencer: accepts opcode, ModR/M and 0..2 displacement
// bytes over a valid/ready handshake, holds the decoded fields for the
// register-address decoder, then runs the one-hot execution beats.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. byte_ready depends only on the current state
// (high everywhere but EXEC), never on byte_valid.
module modrm_sequencer
  import modrm_sequencer_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             exec_stall,
  output logic             d,
  output logic             w,
  output logic [2:0]       _reg,
  output logic [2:0]       r_m,
  output logic [1:0]       MOD,
  output logic             DST,
  output logic             EXC,
  output logic [BEATS-1:0] T,
  output logic [15:0]      disp,
  output logic             illegal,
  output logic             done
);

  seq_state_e state_q, state_d;

  logic        d_q, d_d;
  logic        w_q, w_d;
  logic [2:0]  reg_q, reg_d;
  logic [2:0]  rm_q, rm_d;
  logic [1:0]  mod_q, mod_d;
  logic        dst_q, dst_d;
  logic        exc_q, exc_d;
  logic [15:0] disp_q, disp_d;
  logic        disp_two_q, disp_two_d;  // two displacement bytes pending
  logic        illegal_q, illegal_d;

  logic        xfer;
  logic        beat_start;
  logic        beat_last;
  op_kind_e    op_kind;
  logic        op_legal;

  assign byte_ready = (state_q != EXEC);
  assign xfer       = byte_valid & byte_ready;
  assign op_kind    = decode_opcode(byte_in);
  assign op_legal   = (op_kind != OP_NONE);

  // Fetch FSM: next state and beat start.
  always_comb begin
    state_d    = state_q;
    beat_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer && op_legal) state_d = MODRM;
      end
      MODRM: begin
        if (xfer) begin
          if (byte_in[7:6] == MOD_REG) begin
            state_d    = EXEC;
            beat_start = 1'b1;
          end else if ((byte_in[7:6] == 2'b00) && (byte_in[2:0] != DIRECT_RM)) begin
            state_d    = EXEC;
            beat_start = 1'b1;
          end else begin
            state_d = DISP_LO;
          end
        end
      end
      DISP_LO: begin
        if (xfer) begin
          if (disp_two_q) begin
            state_d = DISP_HI;
          end else begin
            state_d    = EXEC;
            beat_start = 1'b1;
          end
        end
      end
      DISP_HI: begin
        if (xfer) begin
          state_d    = EXEC;
          beat_start = 1'b1;
        end
      end
      EXEC: begin
        if (beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Field capture: opcode bits, ModR/M fields and displacement bytes.
  always_comb begin
    d_d        = d_q;
    w_d        = w_q;
    reg_d      = reg_q;
    rm_d       = rm_q;
    mod_d      = mod_q;
    dst_d      = dst_q;
    exc_d      = exc_q;
    disp_d     = disp_q;
    disp_two_d = disp_two_q;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (op_legal) begin
            // XCHG and MOV-imm have a fixed direction; bit 1 is opcode.
            d_d    = ((op_kind == OP_ALU) || (op_kind == OP_MOV)) ? byte_in[1] : 1'b0;
            w_d    = byte_in[0];
            dst_d  = (op_kind == OP_MOVI);
            exc_d  = (op_kind == OP_XCHG);
            disp_d = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      MODRM: begin
        if (xfer) begin
          mod_d      = byte_in[7:6];
          reg_d      = byte_in[5:3];
          rm_d       = byte_in[2:0];
          disp_two_d = (byte_in[7:6] == 2'b10) ||
                       ((byte_in[7:6] == 2'b00) && (byte_in[2:0] == DIRECT_RM));
        end
      end
      DISP_LO: begin
        if (xfer) begin
          disp_d[7:0] = byte_in;
          if (!disp_two_q) disp_d[15:8] = {8{byte_in[7]}};
        end
      end
      DISP_HI: begin
        if (xfer) disp_d[15:8] = byte_in;
      end
      default: ;
    endcase
  end

  // Field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q        <= 1'b0;
      w_q        <= 1'b0;
      reg_q      <= '0;
      rm_q       <= '0;
      mod_q      <= '0;
      dst_q      <= 1'b0;
      exc_q      <= 1'b0;
      disp_q     <= '0;
      disp_two_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      d_q        <= d_d;
      w_q        <= w_d;
      reg_q      <= reg_d;
      rm_q       <= rm_d;
      mod_q      <= mod_d;
      dst_q      <= dst_d;
      exc_q      <= exc_d;
      disp_q     <= disp_d;
      disp_two_q <= disp_two_d;
      illegal_q  <= illegal_d;
    end
  end

  modrm_beat_gen #(
    .BEATS(BEATS)
  ) u_beat_gen (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (beat_start),
    .stall_i (exec_stall),
    .t_o     (T),
    .done_o  (done),
    .last_o  (beat_last)
  );

  assign d       = d_q;
  assign w       = w_q;
  assign _reg    = reg_q;
  assign r_m     = rm_q;
  assign MOD     = mod_q;
  assign DST     = dst_q;
  assign EXC     = exc_q;
  assign disp    = disp_q;
  assign illegal = illegal_q;

endmodule
